// File: rtl/rsw_pkg.sv
// Shared definitions for the restriction sweep controllers.
// Holds the sweep FSM state codes, the function input width and the
// MISR polynomial/seed used by rsw_misr.
package rsw_pkg;

    localparam int unsigned N_IN = 16;

    // FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] MISR_POLY = 16'h6801;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/rsw_misr.sv
// 16-bit serial-input MISR with enable and synchronous seed load.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (loads seed)
//   load      - reload seed (priority over en)
//   en        - shift in din this cycle
//   din       - serial data bit
//   sig       - current signature
module rsw_misr
    import rsw_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ ({16{sig[15] ^ din}} & MISR_POLY);
        end
    end

endmodule

// File: rtl/restriction_sweep_ctrl.sv
// Sweeps a 16-input function over the affine subspace base ^ span(g[0..k-1])
// in Gray-code order, counting onset points and compressing fn_y into a MISR.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - begin a sweep (honoured in IDLE/DONE only)
//   pause      - freeze enumeration, delay line and accumulators
//   base       - affine offset, captured at start
//   gen_flat   - generators, g[j] = gen_flat[j*N_IN +: N_IN], captured at start
//   k_dim      - subspace dimension (clamped to K_MAX), captured at start
//   fn_x       - registered vector driven to the function
//   fn_y       - function output, valid LAT cycles after fn_x
//   busy       - high while RUN or FLUSH
//   done       - one-cycle completion pulse
//   onset_cnt  - number of sampled points with fn_y = 1
//   signature  - MISR over fn_y in enumeration order
//   is_const   - function constant over the subspace (valid at done)
module restriction_sweep_ctrl
    import rsw_pkg::*;
#(
    parameter int unsigned K_MAX = 8,
    parameter int unsigned LAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic [N_IN-1:0]       base,
    input  logic [K_MAX*N_IN-1:0] gen_flat,
    input  logic [3:0]            k_dim,
    output logic [N_IN-1:0]       fn_x,
    input  logic                  fn_y,
    output logic                  busy,
    output logic                  done,
    output logic [K_MAX:0]        onset_cnt,
    output logic [15:0]           signature,
    output logic                  is_const
);

    localparam int unsigned CW  = K_MAX + 1;
    localparam int unsigned KW  = $clog2(K_MAX + 1);
    localparam int unsigned IW  = K_MAX;
    localparam int unsigned TZW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    logic [1:0]                  state_q, state_d;
    logic [IW-1:0]               i_q, i_d;
    logic [KW-1:0]               k_q, k_d;
    logic [K_MAX-1:0][N_IN-1:0]  gens_q, gens_d;
    logic [N_IN-1:0]             fn_x_d;
    logic [K_MAX:0]              onset_d;
    logic                        busy_d, done_d, is_const_d;

    logic                        run_step_c, sample_c, pend_c, misr_load_c, misr_en_c;
    logic [IW-1:0]               last_i_c, i_inc_c;
    logic [TZW-1:0]              tz_c;

    assign run_step_c = (state_q == ST_RUN) && !pause;
    assign misr_en_c  = sample_c && !pause;
    assign last_i_c   = IW'((32'd1 << k_q) - 32'd1);
    assign i_inc_c    = i_q + IW'(1);

    // Sample-valid delay line: a step's sample is taken LAT cycles after its vector is driven
    if (LAT == 0) begin : g_no_lat
        assign sample_c = run_step_c;
        assign pend_c   = 1'b0;
    end else begin : g_lat
        logic [LAT-1:0] vld_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else if (!pause) begin
                vld_q <= LAT'({vld_q, run_step_c});
            end
        end
        assign sample_c = vld_q[LAT-1];
        assign pend_c   = |vld_q;
    end

    // Trailing-zero count of i+1 selects the generator flipped by the Gray step
    always_comb begin
        tz_c = '0;
        for (int j = K_MAX - 1; j >= 0; j--) begin
            if (i_inc_c[j]) tz_c = TZW'(j);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        k_d         = k_q;
        gens_d      = gens_q;
        fn_x_d      = fn_x;
        onset_d     = onset_cnt;
        done_d      = 1'b0;
        is_const_d  = is_const;
        misr_load_c = 1'b0;

        if (misr_en_c) onset_d = onset_cnt + CW'(fn_y);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    k_d         = (32'(k_dim) > K_MAX) ? KW'(K_MAX) : KW'(k_dim);
                    gens_d      = gen_flat;
                    fn_x_d      = base;
                    i_d         = '0;
                    onset_d     = '0;
                    is_const_d  = 1'b0;
                    misr_load_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    if (i_q == last_i_c) begin
                        state_d = ST_FLUSH;
                    end else begin
                        i_d    = i_inc_c;
                        fn_x_d = fn_x ^ gens_q[tz_c];
                    end
                end
            end
            ST_FLUSH: begin
                if (!pause && !pend_c) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    is_const_d = (onset_cnt == '0) || (onset_cnt == CW'(32'd1 << k_q));
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            k_q       <= '0;
            gens_q    <= '0;
            fn_x      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            onset_cnt <= '0;
            is_const  <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            k_q       <= k_d;
            gens_q    <= gens_d;
            fn_x      <= fn_x_d;
            busy      <= busy_d;
            done      <= done_d;
            onset_cnt <= onset_d;
            is_const  <= is_const_d;
        end
    end

    rsw_misr u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load_c),
        .en   (misr_en_c),
        .din  (fn_y),
        .sig  (signature)
    );

endmodule
